// File: rtl/lab06_result_stat_if.sv
// lab06_result_stat_if: sample stream in, burst summary out, for the lab06 statistics stage
interface lab06_result_stat_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 4
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_result;
    logic                     out_valid;
    logic [CNT_W-1:0]         out_count;
    logic [DATA_W+CNT_W-1:0]  out_sum;
    logic [DATA_W-1:0]        out_max;
    logic [DATA_W-1:0]        out_min;
    logic                     out_ovf;

    modport master (
        output in_valid, in_result,
        input  out_valid, out_count, out_sum, out_max, out_min, out_ovf
    );

    modport slave (
        input  in_valid, in_result,
        output out_valid, out_count, out_sum, out_max, out_min, out_ovf
    );
endinterface

// File: rtl/lab06_result_stat.sv
// lab06_result_stat: per-burst count/sum/max/min/overflow summary of the lab06_1 result stream
module lab06_result_stat #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lab06_result_stat_if.slave   bus
);
    localparam int SUM_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ACC, REPORT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic [DATA_W-1:0]  out_max_q, out_max_d;
    logic [DATA_W-1:0]  out_min_q, out_min_d;
    logic               out_ovf_q, out_ovf_d;

    logic               start, take, drop, done;
    logic [SUM_W-1:0]   sample_ext;

    // Next-state: a burst starts from IDLE/REPORT, accumulates in ACC, and its
    // summary is latched into the output registers on the first idle cycle.
    // Outputs are zero in every cycle that is not the single report cycle.
    always_comb begin
        sample_ext  = {{CNT_W{bus.in_result[DATA_W-1]}}, bus.in_result};
        start       = bus.in_valid && (state_q != ACC);
        take        = bus.in_valid && (state_q == ACC) && (cnt_q != CNT_MAX);
        drop        = bus.in_valid && (state_q == ACC) && (cnt_q == CNT_MAX);
        done        = !bus.in_valid && (state_q == ACC);
        state_d     = bus.in_valid ? ACC : (state_q == ACC ? REPORT : IDLE);
        cnt_d       = start ? CNT_W'(1) : take ? cnt_q + CNT_W'(1) : done ? '0 : cnt_q;
        sum_d       = start ? sample_ext : take ? sum_q + sample_ext : done ? '0 : sum_q;
        max_d       = start ? bus.in_result
                    : (take && ($signed(bus.in_result) > $signed(max_q))) ? bus.in_result
                    : done ? '0 : max_q;
        min_d       = start ? bus.in_result
                    : (take && ($signed(bus.in_result) < $signed(min_q))) ? bus.in_result
                    : done ? '0 : min_q;
        ovf_d       = drop ? 1'b1 : (start || done) ? 1'b0 : ovf_q;
        out_valid_d = done;
        out_count_d = done ? cnt_q : '0;
        out_sum_d   = done ? sum_q : '0;
        out_max_d   = done ? max_q : '0;
        out_min_d   = done ? min_q : '0;
        out_ovf_d   = done ? ovf_q : 1'b0;
    end

    // State, accumulator and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            min_q       <= min_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_sum_q   <= out_sum_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_lab06_result_stat.sv
// tb_lab06_result_stat: directed and random bursts checked against a queue-based burst model
module tb_lab06_result_stat;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lab06_result_stat_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    lab06_result_stat #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared = 0;
    int mismatched = 0;
    int q[$];
    bit in_burst = 0;
    bit ovf = 0;
    int cap_cnt, cap_sum, cap_max, cap_min, cap_ovf;

    task automatic chk(string tag, int got, int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check every output after the edge.
    task automatic step(bit v, int val, bit rn = 1'b1);
        bit pulse = 0;
        int e_cnt = 0, e_sum = 0, e_max = 0, e_min = 0, e_ovf = 0;
        rst_n = rn;
        bus.in_valid = v;
        bus.in_result = DATA_W'(val);
        if (!rn) begin
            q.delete();
            in_burst = 0;
            ovf = 0;
        end else if (v) begin
            if (q.size() < CMAX) q.push_back(val);
            else ovf = 1;
            in_burst = 1;
        end else if (in_burst) begin
            pulse = 1;
            e_cnt = q.size();
            e_max = q[0];
            e_min = q[0];
            foreach (q[i]) begin
                e_sum += q[i];
                if (q[i] > e_max) e_max = q[i];
                if (q[i] < e_min) e_min = q[i];
            end
            e_ovf = ovf;
            q.delete();
            in_burst = 0;
            ovf = 0;
        end
        @(posedge clk);
        #1;
        cap_cnt = int'(bus.out_count);
        cap_sum = int'($signed(bus.out_sum));
        cap_max = int'($signed(bus.out_max));
        cap_min = int'($signed(bus.out_min));
        cap_ovf = int'(bus.out_ovf);
        chk("out_valid", int'(bus.out_valid), int'(pulse));
        chk("out_count", cap_cnt, e_cnt);
        chk("out_sum", cap_sum, e_sum);
        chk("out_max", cap_max, e_max);
        chk("out_min", cap_min, e_min);
        chk("out_ovf", cap_ovf, e_ovf);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        // reset state
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0);
        // single sample
        step(1, -5);
        step(0, 0);
        chk("t1_count", cap_cnt, 1);
        chk("t1_sum", cap_sum, -5);
        chk("t1_max", cap_max, -5);
        chk("t1_min", cap_min, -5);
        step(0, 0);
        // mixed burst
        step(1, 3);
        step(1, -7);
        step(1, 12);
        step(1, 0);
        step(0, 0);
        chk("t2_count", cap_cnt, 4);
        chk("t2_sum", cap_sum, 8);
        chk("t2_max", cap_max, 12);
        chk("t2_min", cap_min, -7);
        step(0, 0);
        // overflow
        for (int i = 0; i < 17; i++) step(1, 31);
        step(0, 0);
        chk("t3_count", cap_cnt, 15);
        chk("t3_sum", cap_sum, 465);
        chk("t3_ovf", cap_ovf, 1);
        step(0, 0);
        // negative extreme, exactly full
        for (int i = 0; i < 15; i++) step(1, -32);
        step(0, 0);
        chk("t4_count", cap_cnt, 15);
        chk("t4_sum", cap_sum, -480);
        chk("t4_ovf", cap_ovf, 0);
        step(0, 0);
        // back-to-back bursts, second starts in the report cycle
        step(1, 1);
        step(1, 2);
        step(0, 0);
        chk("t5a_count", cap_cnt, 2);
        chk("t5a_sum", cap_sum, 3);
        step(1, -1);
        step(0, 0);
        chk("t5b_count", cap_cnt, 1);
        chk("t5b_sum", cap_sum, -1);
        step(0, 0);
        // reset mid-burst
        step(1, 4);
        step(1, 5);
        step(0, 0, 0);
        step(0, 0);
        step(1, 6);
        step(0, 0);
        chk("t6_count", cap_cnt, 1);
        chk("t6_sum", cap_sum, 6);
        step(0, 0);
        // random traffic, including long runs and occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) step(0, 0, 0);
            else if ($urandom_range(0, 79) == 0)
                for (int k = 0; k < 18; k++) step(1, int'($urandom_range(0, 63)) - 32);
            else step($urandom_range(0, 9) < 7, int'($urandom_range(0, 63)) - 32);
        end
        step(0, 0);
        step(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lab06_result_stat.md
# lab06_result_stat

Downstream statistics stage for the lab06 arithmetic unit. It consumes the `out_valid`/`out_result` stream that `lab06_1` produces, grouping consecutive valid results into a burst. When a burst ends, it emits a one-cycle summary of that burst: sample count, signed sum, maximum, minimum and an overflow flag. It sits directly after `lab06_1` in the lab06 datapath and in the lab06 benches.

## Interface
- `DATA_W`, default 6: width of the signed input sample; matches `lab06_1` `out_result`.
- `CNT_W`, default 4: width of the sample counter; a burst holds at most 2^CNT_W-1 samples.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: sample strobe; connected to `lab06_1` `out_valid`.
- `in_result` input DATA_W: signed sample; connected to `lab06_1` `out_result`; ignored when `in_valid`=0.
- `out_valid` output 1: summary strobe, high for exactly one cycle per burst.
- `out_count` output CNT_W: unsigned number of accepted samples.
- `out_sum` output DATA_W+CNT_W: signed sum of accepted samples.
- `out_max` output DATA_W: signed maximum of accepted samples.
- `out_min` output DATA_W: signed minimum of accepted samples.
- `out_ovf` output 1: the burst exceeded 2^CNT_W-1 samples; excess samples were dropped.

## Operation
- **Burst definition:** a maximal run of consecutive cycles with `in_valid`=1, starting from IDLE or REPORT.
- **FSM states:** IDLE, ACC, REPORT.
- **IDLE**
  - `in_valid`=1: load count=1, sum=sign-extended sample, max=min=sample, ovf=0; go to ACC.
  - Otherwise: stay in IDLE.
- **ACC, `in_valid`=1**
  - If count < 2^CNT_W-1: count+1, sum+=sample, max/min updated by signed compare.
  - Otherwise: sample dropped, ovf=1, all other accumulators held.
  - Stay in ACC.
- **ACC, `in_valid`=0**
  - Copy count/sum/max/min/ovf into the output registers.
  - Clear the accumulators.
  - Go to REPORT.
- **REPORT:** `out_valid`=1 for this cycle only.
  - `in_valid`=1: start a new burst exactly as from IDLE (load; go to ACC). The new burst does not disturb the summary currently on the outputs.
  - Otherwise: go to IDLE.
- **Output gating:** all summary outputs are 0 whenever `out_valid`=0.
- **Arithmetic:** sum is the sign-extended addition at width DATA_W+CNT_W. It cannot overflow: the range is -480..465 at defaults, within -512..511. Max/min compares are signed.
- **Reset:** `rst_n`=0 sampled at an edge forces IDLE and clears all accumulators and outputs.
  - Reset mid-burst discards that burst; no summary is produced for it.
  - Reset during REPORT drops `out_valid` at that edge.

## Timing
- **Reset values:** `out_valid`=0, `out_count`=0, `out_sum`=0, `out_max`=0, `out_min`=0, `out_ovf`=0.
- **Latency:** last sample of the burst accepted at edge k; `in_valid`=0 in the cycle after it, sampled at edge k+1; `out_valid`=1 in the cycle between edges k+1 and k+2.
- **Pacing:** one `out_valid` pulse per burst. `out_valid` is never high on two consecutive cycles, because a minimum of one idle cycle separates bursts.
- **Input acceptance:** one sample per cycle, no backpressure. The block never stalls its upstream.
- **Back-to-back bursts:** a sample arriving in the REPORT cycle is accepted. Its summary appears no earlier than two cycles after the pulse for the previous burst.
- **Output registers:** all outputs come from registers; no combinational path from the inputs.

## Test plan
1. **Single sample:** `in_result`=-5 for one cycle -> one pulse with count=1, sum=-5, max=-5, min=-5, ovf=0.
2. **Mixed burst:** 3, -7, 12, 0 on consecutive cycles -> count=4, sum=8, max=12, min=-7, ovf=0. The pulse occurs exactly 2 edges after the last sample.
3. **Overflow:** 17 consecutive samples of 31 -> count=15, sum=465, max=min=31, ovf=1.
4. **Negative extreme:** 15 samples of -32 -> count=15, sum=-480, max=min=-32, ovf=0.
5. **Back-to-back bursts:** burst {1,2}, then one idle cycle, then burst {-1} starting in the REPORT cycle.
   - First pulse: count=2, sum=3, max=2, min=1.
   - Second pulse: count=1, sum=-1, max=min=-1.
6. **Reset mid-burst:** `rst_n`=0 for one cycle after samples {4,5}.
   - No `out_valid`; all outputs stay 0.
   - A following burst {6} reports count=1, sum=6, with no residue from {4,5}.
